// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
//
// Store-and-forward AXI-Stream packet FIFO. A packet becomes visible to the
// read side only once its tlast beat has been written, so the consumer never
// sees a partial frame. The upstream is never stalled. If a packet runs into a
// full buffer, the whole packet is discarded and counted.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             input stream (tdata, tkeep, tvalid, tlast, tready)
//   m_axis_*             registered output stream (tdata, tkeep, tvalid,
//                        tlast) and downstream tready
//   pkt_stored           committed packets whose tlast has not yet left
//   drop_count           dropped packets, saturating at all-ones
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter int TDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [CNT_WIDTH-1:0]     pkt_stored,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int PW         = AW + 1;
    localparam int BEAT_W     = TDATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } wr_state_e;

    wr_state_e state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic                   ready_q;
    logic [BEAT_W-1:0]      mem_q [DEPTH];
    logic [BEAT_W-1:0]      rd_beat;

    logic [TDATA_WIDTH-1:0] m_data_q;
    logic [KEEP_WIDTH-1:0]  m_keep_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic [CNT_WIDTH-1:0]   pkt_stored_q;
    logic [CNT_WIDTH-1:0]   drop_count_q;

    logic accept;
    logic full;
    logic mem_we;
    logic commit;
    logic drop_inc;
    logic avail;
    logic load;
    logic pkt_dec;

    assign accept = s_axis_tvalid && ready_q;
    // Memory occupancy only; the output register is an extra slot on top.
    assign full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_PASS;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            ready_q     <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_PASS: if (full && !s_axis_tlast) state_d = ST_DROP;
                ST_DROP: if (s_axis_tlast)          state_d = ST_PASS;
                default:                            state_d = ST_PASS;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: outputs (memory write, pointer moves, commit, drop)
    // ------------------------------------------------------------------
    always_comb begin
        mem_we      = 1'b0;
        commit      = 1'b0;
        drop_inc    = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        if (accept) begin
            case (state_q)
                ST_PASS: begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (s_axis_tlast) begin
                            commit      = 1'b1;
                            wr_commit_d = wr_ptr_q + PW'(1);
                        end
                    end else begin
                        // Roll back whatever part of this packet was written.
                        wr_ptr_d = wr_commit_q;
                        drop_inc = s_axis_tlast;
                    end
                end
                ST_DROP: drop_inc = s_axis_tlast;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers define which
    // entries are meaningful, so clearing the contents buys nothing.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

    // ------------------------------------------------------------------
    // Read side: only beats behind wr_commit are eligible.
    // Writes never target rd_ptr's slot because full blocks them.
    // ------------------------------------------------------------------
    assign rd_beat  = mem_q[rd_ptr_q[AW-1:0]];
    assign avail    = rd_ptr_q != wr_commit_q;
    assign load     = avail && (!m_valid_q || m_axis_tready);
    assign rd_ptr_d = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
    assign pkt_dec  = m_valid_q && m_axis_tready && m_last_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr_q  <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            if (load) begin
                {m_data_q, m_keep_q, m_last_q} <= rd_beat;
                m_valid_q                      <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status counters
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_stored_q <= '0;
            drop_count_q <= '0;
        end else begin
            case ({commit, pkt_dec})
                2'b10:   pkt_stored_q <= pkt_stored_q + CNT_WIDTH'(1);
                2'b01:   pkt_stored_q <= pkt_stored_q - CNT_WIDTH'(1);
                default: ;
            endcase
            if (drop_inc && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_stored    = pkt_stored_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_fifo
//
// Drives axis_pkt_fifo (DEPTH=4, 4-bit counters) with directed scenarios and a
// randomized phase, comparing every cycle against a queue-based reference:
// committed beats, the packet currently being written, and the output slot.
// -----------------------------------------------------------------------------
module tb_axis_pkt_fifo;

    localparam int W     = 32;
    localparam int KW    = W / 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [W-1:0]  s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] pkt_stored;
    logic [CW-1:0] drop_count;

    always #5 aclk = ~aclk;

    axis_pkt_fifo #(
        .TDATA_WIDTH(W),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pkt_stored   (pkt_stored),
        .drop_count   (drop_count)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    // Reference model state
    beat_t committed[$];
    beat_t partial[$];
    bit    dropping;
    bit    ov;
    beat_t ob;
    int    drops;
    bit    rdy;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Packets whose tlast is still inside: in memory or in the output slot.
    function automatic int model_pkt();
        int n;
        n = 0;
        foreach (committed[i]) if (committed[i].last) n++;
        if (ov && ob.last) n++;
        return n;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit    full;
        bit    acc;
        beat_t b;
        if (!aresetn) begin
            committed.delete();
            partial.delete();
            dropping = 0;
            ov       = 0;
            ob       = '0;
            drops    = 0;
            rdy      = 0;
            return;
        end
        full = (committed.size() + partial.size()) == DEPTH;
        acc  = s_axis_tvalid && rdy;
        if (committed.size() > 0 && (!ov || m_axis_tready)) begin
            ob = committed.pop_front();
            ov = 1;
        end else if (m_axis_tready) begin
            ov = 0;
        end
        if (acc) begin
            b = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
            if (dropping) begin
                if (s_axis_tlast) begin
                    if (drops < CMAX) drops++;
                    dropping = 0;
                end
            end else if (!full) begin
                partial.push_back(b);
                if (s_axis_tlast) begin
                    foreach (partial[i]) committed.push_back(partial[i]);
                    partial.delete();
                end
            end else begin
                partial.delete();
                if (s_axis_tlast) begin
                    if (drops < CMAX) drops++;
                end else begin
                    dropping = 1;
                end
            end
        end
        rdy = 1;
    endtask

    task automatic check_outputs();
        check("s_tready", 64'(s_axis_tready), 64'(rdy));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(ov));
        if (ov) begin
            check("m_tdata", 64'(m_axis_tdata), 64'(ob.data));
            check("m_tkeep", 64'(m_axis_tkeep), 64'(ob.keep));
            check("m_tlast", 64'(m_axis_tlast), 64'(ob.last));
        end
        check("pkt_stored", 64'(pkt_stored), 64'(model_pkt()));
        check("drop_count", 64'(drop_count), 64'(drops));
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic step(input bit v, input logic [W-1:0] d, input logic [KW-1:0] k,
                        input bit l, input bit r);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        m_axis_tready = r;
        model_step();
        @(negedge aclk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, r);
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        idle(n, 0);
        aresetn = 1'b1;
        idle(1, 0);
    endtask

    int        bp_seen;
    int        bp_max;
    int        rem;
    bit        rv;
    bit        rr;
    bit        rl;
    logic [W-1:0]  rd;
    logic [KW-1:0] rk;

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge aclk);

        // Reset state
        aresetn = 1'b0;
        idle(2, 0);
        check("rst_tready", 64'(s_axis_tready), 64'(0));
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        aresetn = 1'b1;
        idle(1, 0);
        check("rel_tready", 64'(s_axis_tready), 64'(1));

        // Single packet, latency of two cycles after tlast
        step(1, 32'h11, 4'hF, 0, 1);
        step(1, 32'h22, 4'hF, 0, 1);
        check("sp_no_early", 64'(m_axis_tvalid), 64'(0));
        step(1, 32'h33, 4'hF, 1, 1);
        check("sp_c1_valid", 64'(m_axis_tvalid), 64'(0));
        check("sp_c1_pkt", 64'(pkt_stored), 64'(1));
        idle(1, 1);
        check("sp_c2_valid", 64'(m_axis_tvalid), 64'(1));
        check("sp_b0", 64'(m_axis_tdata), 64'(32'h11));
        idle(1, 1);
        check("sp_b1", 64'(m_axis_tdata), 64'(32'h22));
        idle(1, 1);
        check("sp_b2", 64'(m_axis_tdata), 64'(32'h33));
        check("sp_b2_last", 64'(m_axis_tlast), 64'(1));
        idle(1, 1);
        check("sp_end_valid", 64'(m_axis_tvalid), 64'(0));
        check("sp_end_pkt", 64'(pkt_stored), 64'(0));
        check("sp_drops", 64'(drop_count), 64'(0));

        // No partial release
        step(1, 32'hB0, 4'hF, 0, 1);
        step(1, 32'hB1, 4'h3, 0, 1);
        for (int i = 0; i < 10; i++) begin
            idle(1, 1);
            check("np_hold", 64'(m_axis_tvalid), 64'(0));
        end
        step(1, 32'hB2, 4'h0, 1, 1);
        check("np_c1", 64'(m_axis_tvalid), 64'(0));
        idle(1, 1);
        check("np_c2", 64'(m_axis_tvalid), 64'(1));
        check("np_first", 64'(m_axis_tdata), 64'(32'hB0));
        idle(4, 1);

        // Overflow drop with downstream stalled
        do_reset(1);
        step(1, 32'hC0, 4'hF, 0, 0);
        step(1, 32'hC1, 4'hF, 0, 0);
        step(1, 32'hC2, 4'hF, 1, 0);
        step(1, 32'hD0, 4'hF, 0, 0);
        step(1, 32'hD1, 4'hF, 0, 0);
        step(1, 32'hD2, 4'hF, 1, 0);
        check("ovf_drops", 64'(drop_count), 64'(1));
        check("ovf_pkt", 64'(pkt_stored), 64'(1));
        check("ovf_hold", 64'(m_axis_tdata), 64'(32'hC0));
        idle(1, 1);
        check("ovf_a1", 64'(m_axis_tdata), 64'(32'hC1));
        idle(1, 1);
        check("ovf_a2", 64'(m_axis_tdata), 64'(32'hC2));
        idle(1, 1);
        check("ovf_empty", 64'(m_axis_tvalid), 64'(0));
        check("ovf_pkt_end", 64'(pkt_stored), 64'(0));

        // Oversize packet followed by a normal one
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1, 32'hE0 + 32'(i), 4'hF, i == 5, 1);
        step(1, 32'hA0, 4'hF, 0, 1);
        step(1, 32'hA1, 4'hF, 1, 1);
        check("big_drops", 64'(drop_count), 64'(1));
        idle(1, 1);
        check("big_a0", 64'(m_axis_tdata), 64'(32'hA0));
        idle(1, 1);
        check("big_a1", 64'(m_axis_tdata), 64'(32'hA1));
        check("big_a1_last", 64'(m_axis_tlast), 64'(1));
        idle(2, 1);

        // Backpressure: toggling tready, order preserved
        do_reset(1);
        bp_seen = 0;
        bp_max  = 0;
        for (int c = 0; c < 25; c++) begin
            if (m_axis_tvalid && (c % 2 == 0)) begin
                check("bp_order", 64'(m_axis_tdata), 64'(32'h50 + 32'(bp_seen)));
                bp_seen++;
            end
            step(c < 5, 32'h50 + 32'(c), 4'hF, 1, c % 2 == 0);
            if (int'(pkt_stored) > bp_max) bp_max = int'(pkt_stored);
        end
        check("bp_count", 64'(bp_seen), 64'(5));
        check("bp_max_ok", 64'(bp_max <= 5), 64'(1));

        // drop_count saturation
        do_reset(1);
        for (int i = 0; i < 24; i++) step(1, 32'h100 + 32'(i), 4'hF, 1, 0);
        check("sat_drops", 64'(drop_count), 64'(CMAX));
        check("sat_pkt", 64'(pkt_stored), 64'(5));
        idle(8, 1);
        check("sat_drain", 64'(pkt_stored), 64'(0));

        // Reset mid-operation
        do_reset(1);
        step(1, 32'hF0, 4'hF, 1, 0);
        step(1, 32'hF1, 4'hF, 1, 0);
        step(1, 32'hF2, 4'hF, 0, 0);
        aresetn = 1'b0;
        idle(1, 0);
        check("mr_valid", 64'(m_axis_tvalid), 64'(0));
        check("mr_pkt", 64'(pkt_stored), 64'(0));
        check("mr_drops", 64'(drop_count), 64'(0));
        aresetn = 1'b1;
        idle(1, 1);
        step(1, 32'h77, 4'h5, 1, 1);
        idle(1, 1);
        check("mr_new", 64'(m_axis_tdata), 64'(32'h77));
        check("mr_new_last", 64'(m_axis_tlast), 64'(1));
        idle(1, 1);
        check("mr_new_pkt", 64'(pkt_stored), 64'(0));

        // Randomized traffic
        do_reset(1);
        rem = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset(1);
                rem = 0;
            end else begin
                if (rem == 0) rem = $urandom_range(1, 6);
                rv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 2) != 0);
                rd = $urandom;
                rk = KW'($urandom);
                rl = (rem == 1);
                step(rv, rd, rk, rl, rr);
                if (rv) rem--;
            end
        end
        idle(12, 1);
        check("rnd_drained", 64'(m_axis_tvalid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
